// File: rtl/vga_timing_gen.sv
// VGA timing and pixel engine: generic H/V timing, CSR-configured stream/pattern sources,
// registered sync/blank/colour outputs with frame and underflow counters.
//
//   state | meaning
//   IDLE  | counters held at 0, outputs parked at reset levels
//   RUN   | scanning frames; enable/mode re-sampled only on the last pixel of a frame
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   COLOR_W  = 8,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   csr_read,
    input  logic                   csr_write,
    input  logic [7:0]             csr_addr,
    input  logic [31:0]            csr_wr_data,
    output logic [31:0]            csr_rd_data,
    input  logic [3*COLOR_W-1:0]   pix_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic                   sof,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = 3 * COLOR_W;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [BW-1:0]   bar_px;
    logic [2:0]      bar_idx;
    logic            ctrl_en;
    logic [1:0]      ctrl_mode;
    logic [1:0]      run_mode;
    logic [PW-1:0]   solid;
    logic [15:0]     frame_cnt;
    logic [15:0]     underflow_cnt;
    logic [31:0]     rd_mux;
    logic [PW-1:0]   pix_rgb;
    logic [PW-1:0]   rgb_q;
    logic [15:0]     h_ext, v_ext;
    logic            running, active, line_end, frame_end, underflow, status_clr;
    logic            unused_wr_bits;

    assign running    = (state == RUN);
    assign line_end   = (h_cnt == H_LAST);
    assign frame_end  = line_end && (v_cnt == V_LAST);
    assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign pix_ready  = running && (run_mode == 2'd0) && active;
    assign underflow  = pix_ready && !pix_valid;
    assign status_clr = csr_write && (csr_addr == 8'd2);
    assign h_ext      = 16'(h_cnt);
    assign v_ext      = 16'(v_cnt);
    assign unused_wr_bits = ^csr_wr_data[31:PW];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ctrl_en) state_nxt = RUN;
            RUN:  if (frame_end && !ctrl_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Bar index tracks h_cnt/BAR_W incrementally so no divider is needed.
    always_ff @(posedge clk) begin
        if (reset || !running || line_end) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_cnt < H_ACT) begin
            if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px  <= bar_px + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                     run_mode <= 2'd0;
        else if (!running || frame_end) run_mode <= ctrl_mode;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (csr_addr)
            8'd0: rd_mux = {29'd0, ctrl_mode, ctrl_en};
            8'd1: rd_mux = 32'(solid);
            8'd2: rd_mux = {underflow_cnt, frame_cnt};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_mode   <= 2'd0;
            solid       <= '0;
            csr_rd_data <= 32'd0;
        end else begin
            if (csr_write && csr_addr == 8'd0) begin
                ctrl_en   <= csr_wr_data[0];
                ctrl_mode <= csr_wr_data[2:1];
            end
            if (csr_write && csr_addr == 8'd1) solid <= csr_wr_data[PW-1:0];
            if (csr_read) csr_rd_data <= rd_mux;
        end
    end

    // A STATUS write in the same cycle as an increment leaves the counters cleared.
    always_ff @(posedge clk) begin
        if (reset || status_clr) begin
            frame_cnt     <= 16'd0;
            underflow_cnt <= 16'd0;
        end else begin
            if (underflow && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
            if (running && frame_end) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_comb begin
        pix_rgb = '0;
        case (run_mode)
            2'd0: pix_rgb = pix_valid ? pix_data : '0;
            2'd1: pix_rgb = {{COLOR_W{!bar_idx[1]}}, {COLOR_W{!bar_idx[2]}}, {COLOR_W{!bar_idx[0]}}};
            2'd2: pix_rgb = ((h_ext & 16'hF) == 16'd0 || (v_ext & 16'hF) == 16'd0) ? '1 : '0;
            2'd3: pix_rgb = solid;
            default: pix_rgb = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !running) begin
            rgb_q       <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= !HS_POL;
            vga_vs      <= !VS_POL;
            sof         <= 1'b0;
        end else begin
            rgb_q       <= active ? pix_rgb : '0;
            vga_blank_n <= active;
            vga_hs      <= (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : !HS_POL;
            vga_vs      <= (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : !VS_POL;
            sof         <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign vga_r      = rgb_q[PW-1 -: COLOR_W];
    assign vga_g      = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga_b      = rgb_q[COLOR_W-1:0];
    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: frame-position reference model feeds an expectation queue,
// a negedge monitor pops and compares every cycle.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int CW = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk, reset, csr_read, csr_write, pix_valid, pix_ready, sof;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wr_data, csr_rd_data;
    logic [23:0] pix_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .COLOR_W(CW), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .csr_read(csr_read), .csr_write(csr_write), .csr_addr(csr_addr),
        .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sof(sof), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic        hs, vs, blank_n, sof, ready, chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: frame position as a single cycle index within the frame.
    bit          m_run;
    int          m_t;
    logic [1:0]  m_mode, m_cmode;
    logic        m_en;
    logic [23:0] m_solid;
    logic [15:0] m_fc, m_uf;

    int drop_left = 0;
    bit valid_on = 0;
    bit rand_valid = 0;

    function automatic logic [23:0] exp_pix(int h, int v, logic [1:0] mode, logic valid,
                                            logic [23:0] data, logic [23:0] sol);
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (mode)
            2'd0: return valid ? data : 24'd0;
            2'd1: return bars[h / (HA / 8)];
            2'd2: return (h % 16 == 0 || v % 16 == 0) ? 24'hFFFFFF : 24'd0;
            default: return sol;
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int h, v;
        bit act, rdy_old;
        e.chk_rd = 1'b0;
        e.rd = 32'd0;
        if (reset) begin
            e.rgb = 24'd0; e.blank_n = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.sof = 1'b0;
            e.chk_rd = 1'b1;
            m_run = 0; m_t = 0; m_mode = 2'd0; m_cmode = 2'd0; m_en = 1'b0;
            m_solid = 24'd0; m_fc = 16'd0; m_uf = 16'd0;
        end else begin
            h = m_t % HT;
            v = m_t / HT;
            act = m_run && h < HA && v < VA;
            if (!m_run) begin
                e.rgb = 24'd0; e.blank_n = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.sof = 1'b0;
            end else begin
                e.blank_n = act;
                e.rgb = act ? exp_pix(h, v, m_mode, pix_valid, pix_data, m_solid) : 24'd0;
                e.hs = !(h >= HA + HF && h < HA + HF + HS);
                e.vs = !(v >= VA + VF && v < VA + VF + VS);
                e.sof = (m_t == 0);
            end
            if (csr_read) begin
                e.chk_rd = 1'b1;
                case (csr_addr)
                    8'd0: e.rd = {29'd0, m_cmode, m_en};
                    8'd1: e.rd = {8'd0, m_solid};
                    8'd2: e.rd = {m_uf, m_fc};
                    default: e.rd = 32'd0;
                endcase
            end
            rdy_old = act && m_mode == 2'd0;
            if (csr_write && csr_addr == 8'd2) begin
                m_fc = 16'd0; m_uf = 16'd0;
            end else begin
                if (rdy_old && !pix_valid && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
                if (m_run && m_t == FT - 1) m_fc = m_fc + 16'd1;
            end
            if (!m_run) begin
                m_mode = m_cmode;
                m_t = 0;
                if (m_en) m_run = 1;
            end else if (m_t == FT - 1) begin
                m_t = 0;
                m_mode = m_cmode;
                if (!m_en) m_run = 0;
            end else begin
                m_t = m_t + 1;
            end
            if (csr_write && csr_addr == 8'd0) begin
                m_en = csr_wr_data[0];
                m_cmode = csr_wr_data[2:1];
            end
            if (csr_write && csr_addr == 8'd1) m_solid = csr_wr_data[23:0];
        end
        e.ready = m_run && m_mode == 2'd0 && (m_t % HT) < HA && (m_t / HT) < VA;
        q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
            chk("hs", 32'(vga_hs), 32'(e.hs));
            chk("vs", 32'(vga_vs), 32'(e.vs));
            chk("blank_n", 32'(vga_blank_n), 32'(e.blank_n));
            chk("sof", 32'(sof), 32'(e.sof));
            chk("pix_ready", 32'(pix_ready), 32'(e.ready));
            chk("sync_n", 32'(vga_sync_n), 32'd0);
            if (e.chk_rd) chk("csr_rd_data", csr_rd_data, e.rd);
        end
    end

    always @(negedge clk) begin
        pix_data = 24'($urandom);
        if (drop_left > 0 && pix_ready) begin
            pix_valid = 1'b0;
            drop_left = drop_left - 1;
        end else if (rand_valid) begin
            pix_valid = ($urandom % 4) != 0;
        end else begin
            pix_valid = valid_on;
        end
    end

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        csr_write = 1'b1; csr_addr = a; csr_wr_data = d;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [7:0] a);
        csr_read = 1'b1; csr_addr = a;
        @(negedge clk);
        csr_read = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        while (!(m_run && m_t == target) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: position %0d not reached, got %0d", target, m_t);
        end
    endtask

    initial begin
        reset = 1'b1; csr_read = 1'b0; csr_write = 1'b0; csr_addr = 8'd0;
        csr_wr_data = 32'd0; pix_data = 24'd0; pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        csr_rd(8'd0); csr_rd(8'd1); csr_rd(8'd2); csr_rd(8'd7);

        csr_wr(8'd1, $urandom);
        csr_wr(8'd0, 32'd1);
        valid_on = 1;
        repeat (3 * FT) @(negedge clk);

        drop_left = 5;
        repeat (FT) @(negedge clk);
        csr_rd(8'd2);
        csr_wr(8'd2, 32'hFFFF_FFFF);
        csr_rd(8'd2);

        wait_pos(2 * HT + 3);
        csr_wr(8'd0, 32'd3);
        repeat (2 * FT + 10) @(negedge clk);
        csr_wr(8'd0, 32'd5);
        repeat (2 * FT) @(negedge clk);
        csr_wr(8'd0, 32'd7);
        repeat (2 * FT) @(negedge clk);
        csr_rd(8'd1); csr_rd(8'd0);

        rand_valid = 1;
        for (int i = 0; i < 12; i++) begin
            csr_wr(8'd0, 32'(($urandom % 4) * 2 + 1));
            if ($urandom % 3 == 0) csr_wr(8'd1, $urandom);
            if ($urandom % 4 == 0) csr_wr(8'(4 + $urandom % 8), $urandom);
            repeat ($urandom_range(20, 200)) @(negedge clk);
            csr_rd(8'($urandom % 4));
        end
        rand_valid = 0;
        valid_on = 1;

        csr_wr(8'd0, 32'd1);
        wait_pos(2 * HT);
        csr_wr(8'd0, 32'd0);
        repeat (FT + 20) @(negedge clk);
        csr_rd(8'd2);
        repeat (100) @(negedge clk);

        csr_wr(8'd0, 32'd1);
        wait_pos(3 * HT + 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        csr_rd(8'd0); csr_rd(8'd2); csr_rd(8'd1);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
